// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared audio definitions: sample/period widths, note period
//               constants (clock cycles per waveform period at 50 MHz) and
//               the state encodings used by the period meter.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int SAMPLE_W = 32;
    localparam int PERIOD_W = 32;

    // Note periods in 50 MHz clock cycles (50e6 / f). These are shared with
    // the tone generators so a measured period can be matched directly.
    localparam logic [PERIOD_W-1:0] C  = 32'd191109;
    localparam logic [PERIOD_W-1:0] D  = 32'd170265;
    localparam logic [PERIOD_W-1:0] E  = 32'd151685;
    localparam logic [PERIOD_W-1:0] F  = 32'd143172;
    localparam logic [PERIOD_W-1:0] G  = 32'd127551;
    localparam logic [PERIOD_W-1:0] A  = 32'd113636;
    localparam logic [PERIOD_W-1:0] B  = 32'd101239;
    localparam logic [PERIOD_W-1:0] C1 = 32'd95556;
    localparam logic [PERIOD_W-1:0] D1 = 32'd85131;
    localparam logic [PERIOD_W-1:0] E1 = 32'd75842;
    localparam logic [PERIOD_W-1:0] F1 = 32'd71586;
    localparam logic [PERIOD_W-1:0] G1 = 32'd63776;
    localparam logic [PERIOD_W-1:0] A1 = 32'd56818;
    localparam logic [PERIOD_W-1:0] B1 = 32'd50619;

    // Measurement FSM: waiting for a reference edge, or accumulating periods.
    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        ARMED  = 1'b1
    } meas_state_t;

    // Schmitt detector level.
    typedef enum logic [0:0] {
        SCH_LOW  = 1'b0,
        SCH_HIGH = 1'b1
    } schmitt_state_t;

endpackage
`default_nettype wire

// File: rtl/note_period_meter_if.sv
`default_nettype none
// ============================================================================
// Module      : note_period_meter_if
// Description : Audio_Controller input FIFO port. The master (the meter)
//               issues pops; the slave (the FIFO) presents the head sample.
// Revision    : 1.0 - initial release
// ============================================================================
interface note_period_meter_if;
    import audio_pkg::*;

    logic                       audio_in_available;
    logic signed [SAMPLE_W-1:0] left_channel_audio_in;
    logic signed [SAMPLE_W-1:0] right_channel_audio_in;
    logic                       read_audio_in;

    modport master (
        input  audio_in_available,
        input  left_channel_audio_in,
        input  right_channel_audio_in,
        output read_audio_in
    );

    modport slave (
        output audio_in_available,
        output left_channel_audio_in,
        output right_channel_audio_in,
        input  read_audio_in
    );

endinterface
`default_nettype wire

// File: rtl/note_period_meter_schmitt_edge.sv
`default_nettype none
// ============================================================================
// Module      : schmitt_edge
// Description : Schmitt trigger on a sample stream. Emits a combinational
//               one-cycle pulse on the LOW->HIGH transition; the level
//               register updates on the same clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module schmitt_edge
    import audio_pkg::*;
#(
    parameter int          SAMPLE_W = audio_pkg::SAMPLE_W,
    parameter logic [31:0] HYST     = 32'd16777216
) (
    input  wire logic                       clock,
    input  wire logic                       resetn,
    input  wire logic                       clear,
    input  wire logic signed [SAMPLE_W-1:0] sample,
    input  wire logic                       sample_valid,
    output logic                            rise
);

    localparam logic signed [SAMPLE_W-1:0] c_hyst_hi = SAMPLE_W'(HYST);
    localparam logic signed [SAMPLE_W-1:0] c_hyst_lo = -c_hyst_hi;

    schmitt_state_t r_state;
    schmitt_state_t w_state_n;
    logic           w_above;
    logic           w_below;

    // Strict comparisons: samples exactly at +/-HYST keep the current level.
    assign w_above = (sample > c_hyst_hi);
    assign w_below = (sample < c_hyst_lo);

    // Level register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= SCH_LOW;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next level and rising-edge pulse; a clear forces LOW and masks the pulse.
    always_comb begin
        w_state_n = r_state;
        rise      = 1'b0;
        if (clear) begin
            w_state_n = SCH_LOW;
        end else if (sample_valid) begin
            case (r_state)
                SCH_LOW: begin
                    if (w_above) begin
                        w_state_n = SCH_HIGH;
                        rise      = 1'b1;
                    end
                end
                SCH_HIGH: begin
                    if (w_below) begin
                        w_state_n = SCH_LOW;
                    end
                end
                default: w_state_n = SCH_LOW;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/note_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : note_period_meter
// Description : Pops stereo samples from the audio input FIFO, detects rising
//               zero crossings with a Schmitt trigger and reports the average
//               of four consecutive crossing intervals in clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module note_period_meter
    import audio_pkg::*;
#(
    parameter int          SAMPLE_W   = audio_pkg::SAMPLE_W,
    parameter int          PERIOD_W   = audio_pkg::PERIOD_W,
    parameter logic [31:0] HYST       = 32'd16777216,
    parameter logic [31:0] MIN_PERIOD = 32'd20000,
    parameter logic [31:0] MAX_PERIOD = 32'd1000000
) (
    input  wire logic                 clock,
    input  wire logic                 resetn,
    input  wire logic                 enable,
    note_period_meter_if.master       fifo,
    output logic [PERIOD_W-1:0]       period,
    output logic                      period_valid,
    output logic                      locked
);

    localparam logic [PERIOD_W-1:0] c_min_period = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] c_max_period = PERIOD_W'(MAX_PERIOD);

    // ---------------------------------------------------------------- fetch
    logic                       r_pop_block;
    logic                       w_read;
    logic signed [SAMPLE_W-1:0] w_sample;
    logic signed [SAMPLE_W-1:0] r_sample;
    logic                       r_sample_vld;

    // r_pop_block holds last cycle's pop; it resets high so no pop can issue
    // in the cycle reset is released, before the FIFO handshake is settled.
    assign w_read             = enable & fifo.audio_in_available & ~r_pop_block;
    assign fifo.read_audio_in = w_read;

    // Halving each channel first keeps the mono sum inside SAMPLE_W.
    assign w_sample = (fifo.left_channel_audio_in >>> 1)
                    + (fifo.right_channel_audio_in >>> 1);

    // Pop spacing and sample capture.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pop_block  <= 1'b1;
            r_sample     <= '0;
            r_sample_vld <= 1'b0;
        end else begin
            r_pop_block  <= w_read;
            r_sample_vld <= w_read;
            if (w_read) begin
                r_sample <= w_sample;
            end
        end
    end

    // ------------------------------------------------------------ detection
    logic w_rise;

    schmitt_edge #(
        .SAMPLE_W (SAMPLE_W),
        .HYST     (HYST)
    ) u_schmitt (
        .clock        (clock),
        .resetn       (resetn),
        .clear        (~enable),
        .sample       (r_sample),
        .sample_valid (r_sample_vld),
        .rise         (w_rise)
    );

    // ------------------------------------------------------ interval counter
    logic [PERIOD_W-1:0] r_cnt;

    // Cycles since the last rising edge, saturating at MAX_PERIOD.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= PERIOD_W'(1);
        end else if (r_cnt < c_max_period) begin
            r_cnt <= r_cnt + PERIOD_W'(1);
        end
    end

    // ------------------------------------------------------ measurement FSM
    meas_state_t           r_state;
    meas_state_t           w_state_n;
    logic [PERIOD_W+1:0]   r_acc;
    logic [PERIOD_W+1:0]   w_acc_n;
    logic [PERIOD_W+1:0]   w_acc_sum;
    logic [1:0]            r_k;
    logic [1:0]            w_k_n;
    logic [PERIOD_W-1:0]   w_period_n;
    logic                  w_valid_n;
    logic                  w_locked_n;
    logic                  w_in_range;

    assign w_acc_sum  = r_acc + {2'b00, r_cnt};
    assign w_in_range = (r_cnt >= c_min_period) && (r_cnt <= c_max_period);

    // State, accumulator and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= SEARCH;
            r_acc        <= '0;
            r_k          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_acc        <= w_acc_n;
            r_k          <= w_k_n;
            period       <= w_period_n;
            period_valid <= w_valid_n;
            locked       <= w_locked_n;
        end
    end

    // Next state: an edge is checked before the timeout so an edge arriving
    // exactly at MAX_PERIOD is still measured.
    always_comb begin
        w_state_n  = r_state;
        w_acc_n    = r_acc;
        w_k_n      = r_k;
        w_period_n = period;
        w_valid_n  = 1'b0;
        w_locked_n = locked;
        if (!enable) begin
            w_state_n  = SEARCH;
            w_acc_n    = '0;
            w_k_n      = '0;
            w_locked_n = 1'b0;
        end else begin
            case (r_state)
                SEARCH: begin
                    if (w_rise) begin
                        w_state_n = ARMED;
                        w_acc_n   = '0;
                        w_k_n     = '0;
                    end
                end
                ARMED: begin
                    if (w_rise) begin
                        if (w_in_range) begin
                            if (r_k == 2'd3) begin
                                w_period_n = w_acc_sum[PERIOD_W+1:2];
                                w_valid_n  = 1'b1;
                                w_locked_n = 1'b1;
                                w_acc_n    = '0;
                                w_k_n      = '0;
                            end else begin
                                w_acc_n = w_acc_sum;
                                w_k_n   = r_k + 2'd1;
                            end
                        end else begin
                            // Out-of-range interval: restart averaging from this edge.
                            w_acc_n    = '0;
                            w_k_n      = '0;
                            w_locked_n = 1'b0;
                        end
                    end else if (r_cnt == c_max_period) begin
                        w_state_n  = SEARCH;
                        w_acc_n    = '0;
                        w_k_n      = '0;
                        w_locked_n = 1'b0;
                    end
                end
                default: begin
                    w_state_n = SEARCH;
                    w_acc_n   = '0;
                    w_k_n     = '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_note_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_period_meter
// Description : Scoreboard bench for note_period_meter. Stimulus pushes the
//               expected averaged period; an independent monitor pops and
//               compares on every period_valid pulse. Timing constants are
//               scaled down (10 clocks per sample) to keep the run short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_period_meter;

    localparam int GAP     = 10;        // clocks between FIFO samples
    localparam int MIN_P   = 200;
    localparam int MAX_P   = 10000;
    localparam int LONG_N  = 100;       // samples per period -> 1000 clocks
    localparam int SHORT_N = 10;        // samples per period -> 100 clocks
    localparam longint EXP_PERIOD = 1000;

    localparam logic signed [31:0] HI_S = 32'sh1000_0000;
    localparam logic signed [31:0] LO_S = -32'sh1000_0000;

    logic        clk;
    logic        resetn;
    logic        enable;
    logic [31:0] period;
    logic        period_valid;
    logic        locked;

    note_period_meter_if fifo_bus ();

    note_period_meter #(
        .MIN_PERIOD (32'd200),
        .MAX_PERIOD (32'd10000)
    ) dut (
        .clock        (clk),
        .resetn       (resetn),
        .enable       (enable),
        .fifo         (fifo_bus.master),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     total = 0;
    int     bad   = 0;
    longint exp_q[$];
    int     valid_cnt = 0;
    int     valid_cyc = -1;
    int     fall_cyc  = -1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard pops, pop spacing, and lock-fall time stamp.
    initial begin
        logic   prev_read;
        logic   prev_locked;
        longint e;
        prev_read   = 1'b0;
        prev_locked = 1'b0;
        forever begin
            @(negedge clk);
            if (fifo_bus.read_audio_in) begin
                check("pop_not_back_to_back", longint'(prev_read), 0);
            end
            prev_read = fifo_bus.read_audio_in;
            if (period_valid) begin
                valid_cnt++;
                valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_period_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("period_at_valid", longint'(period), e);
                    check("locked_at_valid", longint'(locked), 1);
                end
            end
            if (prev_locked && !locked) fall_cyc = cyc;
            prev_locked = locked;
        end
    end

    // One FIFO sample: present it, wait for the pop, then keep the FIFO empty
    // so consecutive pops are exactly GAP clocks apart.
    task automatic send(input logic signed [31:0] s, output int pop_cyc);
        int w;
        fifo_bus.left_channel_audio_in  = s;
        fifo_bus.right_channel_audio_in = s;
        fifo_bus.audio_in_available     = 1'b1;
        w       = 0;
        pop_cyc = -1;
        while (pop_cyc < 0) begin
            @(negedge clk);
            if (fifo_bus.read_audio_in) begin
                pop_cyc = cyc;
            end else begin
                w++;
                if (w > 8) begin
                    check("pop_timeout", 0, 1);
                    break;
                end
            end
        end
        @(posedge clk); #1;
        fifo_bus.audio_in_available = 1'b0;
        repeat (GAP - 1) @(posedge clk);
        #1;
    endtask

    // Square wave, first half high; returns the pop cycle of the last rising sample.
    task automatic send_periods(input int n, input int spp, output int last_edge);
        int pc;
        last_edge = -1;
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < spp; i++) begin
                send((i < spp / 2) ? HI_S : LO_S, pc);
                if (i == 0) last_edge = pc;
            end
        end
    endtask

    // Watchdog.
    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 90000", cyc);
        $fatal(1);
    end

    // Stimulus.
    initial begin
        int le;
        int pops;
        int vc0;
        int pc;
        logic signed [31:0] noise [5];
        noise[0] = 32'sh0100_0000;      // exactly +HYST: not above
        noise[1] = -32'sh0100_0000;     // exactly -HYST
        noise[2] = 32'sh00FF_FFFE;
        noise[3] = 32'sh0000_1234;
        noise[4] = -32'sh00FF_0000;

        // ---- reset held with FIFO non-empty
        resetn = 1'b0;
        enable = 1'b1;
        fifo_bus.audio_in_available     = 1'b1;
        fifo_bus.left_channel_audio_in  = '0;
        fifo_bus.right_channel_audio_in = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("reset_read", longint'(fifo_bus.read_audio_in), 0);
            check("reset_period", longint'(period), 0);
            check("reset_locked", longint'(locked), 0);
            check("reset_valid", longint'(period_valid), 0);
        end
        @(posedge clk); #1;
        fifo_bus.audio_in_available = 1'b0;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ---- handshake: FIFO always non-empty -> pop every other cycle
        fifo_bus.audio_in_available = 1'b1;
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_bus.read_audio_in) pops++;
        end
        check("handshake_pops_in_20", pops, 10);
        @(posedge clk); #1;
        enable = 1'b0;
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_bus.read_audio_in) pops++;
        end
        check("disabled_pops", pops, 0);
        @(posedge clk); #1;
        fifo_bus.audio_in_available = 1'b0;
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ---- lock on a 1000-clock wave
        vc0 = valid_cnt;
        exp_q.push_back(EXP_PERIOD);
        send_periods(5, LONG_N, le);
        check("lock_valid_count", valid_cnt - vc0, 1);
        check("lock_valid_latency", valid_cyc - le, 2);
        check("lock_locked", longint'(locked), 1);
        check("lock_period", longint'(period), EXP_PERIOD);

        // ---- rejection of a too-short period, then relock
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("disable_clears_locked", longint'(locked), 0);
        enable = 1'b1;
        vc0 = valid_cnt;
        send_periods(8, SHORT_N, le);
        check("reject_valid_count", valid_cnt - vc0, 0);
        check("reject_locked", longint'(locked), 0);
        exp_q.push_back(EXP_PERIOD);
        send_periods(5, LONG_N, le);
        check("relock_valid_count", valid_cnt - vc0, 1);
        check("relock_valid_latency", valid_cyc - le, 2);
        check("relock_locked", longint'(locked), 1);

        // ---- hysteresis noise and silence timeout
        vc0 = valid_cnt;
        fall_cyc = -1;
        for (int i = 0; i < 1010; i++) begin
            send(noise[i % 5], pc);
        end
        // last edge acts at the end of pop cycle +1; locked drops MAX_P cycles later
        check("timeout_fall_cycle", fall_cyc - le, MAX_P + 2);
        check("timeout_locked", longint'(locked), 0);
        check("timeout_period_held", longint'(period), EXP_PERIOD);
        check("noise_valid_count", valid_cnt - vc0, 0);

        // ---- reset in the middle of an average
        vc0 = valid_cnt;
        send_periods(3, LONG_N, le);
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midreset_period", longint'(period), 0);
            check("midreset_locked", longint'(locked), 0);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        check("midreset_no_valid", valid_cnt - vc0, 0);
        exp_q.push_back(EXP_PERIOD);
        send_periods(5, LONG_N, le);
        check("post_reset_valid_count", valid_cnt - vc0, 1);
        check("post_reset_valid_latency", valid_cyc - le, 2);
        check("post_reset_locked", longint'(locked), 1);

        repeat (5) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
